// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the memory stage: funct3 encodings,
// the memory FSM state type and the access legality check.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } mem_state_t;

    // Known width code with natural alignment for that width.
    function automatic logic access_legal(input logic [2:0] funct3, input logic [1:0] off);
        logic ok;
        case (funct3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store strobes/replicated data and
// load byte/half extraction with sign or zero extension.
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = ld_rdata[8*gi +: 8];
    end

    assign ld_byte = lane[ld_off];
    assign ld_half = ld_off[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_wstrb = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                st_wstrb = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            F3_W: begin
                st_wstrb = 4'b1111;
                st_wdata = st_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives a req/ready + rvalid data bus,
// formats loads/stores and stalls the pipeline while a transaction is open.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [2:0]            funct3_in,
    input  logic [31:0]           alu_result_in,
    input  logic [31:0]           write_data_in,
    output logic [31:0]           read_data_out,
    output logic                  stall_out,
    output logic                  fault_out,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_wstrb,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_rvalid
);

    mem_state_t            state_reg, state_next;
    logic                  req_reg, we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [3:0]            wstrb_reg;
    logic [31:0]           wdata_reg;
    logic [2:0]            funct3_reg;
    logic [1:0]            off_reg;
    logic [31:0]           hold_reg;

    logic        mem_op, legal;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, ld_data;

    assign mem_op = mem_read_in | mem_write_in;
    assign legal  = mem_op & access_legal(funct3_in, alu_result_in[1:0]);

    load_store_align u_align (
        .st_funct3 (funct3_in),
        .st_off    (alu_result_in[1:0]),
        .st_data   (write_data_in),
        .st_wstrb  (st_wstrb),
        .st_wdata  (st_wdata),
        .ld_funct3 (funct3_reg),
        .ld_off    (off_reg),
        .ld_rdata  (dmem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (legal) state_next = REQ;
            REQ:     if (dmem_ready) state_next = we_reg ? IDLE : RESP;
            RESP:    if (dmem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_out     = 1'b0;
        fault_out     = 1'b0;
        read_data_out = hold_reg;
        case (state_reg)
            IDLE: begin
                fault_out = mem_op & ~legal;
                stall_out = legal;
            end
            // A write finishes on its handshake; a read always waits for RESP.
            REQ:  stall_out = ~(we_reg & dmem_ready);
            RESP: begin
                stall_out = ~dmem_rvalid;
                if (dmem_rvalid) read_data_out = ld_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_reg    <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wstrb_reg  <= 4'b0000;
            wdata_reg  <= 32'h0;
            funct3_reg <= 3'b000;
            off_reg    <= 2'b00;
            hold_reg   <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: if (legal) begin
                    req_reg    <= 1'b1;
                    we_reg     <= mem_write_in;
                    addr_reg   <= {alu_result_in[ADDR_WIDTH-1:2], 2'b00};
                    wstrb_reg  <= mem_write_in ? st_wstrb : 4'b0000;
                    wdata_reg  <= mem_write_in ? st_wdata : 32'h0;
                    funct3_reg <= funct3_in;
                    off_reg    <= alu_result_in[1:0];
                end
                REQ:  if (dmem_ready) req_reg <= 1'b0;
                RESP: if (dmem_rvalid) hold_reg <= ld_data;
                default: ;
            endcase
        end
    end

    assign dmem_req   = req_reg;
    assign dmem_we    = we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_wstrb = wstrb_reg;
    assign dmem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: stores, loads, faults, waits on the bus,
// reset mid-transaction and back-to-back accesses.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in, write_data_in;
    logic [31:0] read_data_out;
    logic        stall_out, fault_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .funct3_in     (funct3_in),
        .alu_result_in (alu_result_in),
        .write_data_in (write_data_in),
        .read_data_out (read_data_out),
        .stall_out     (stall_out),
        .fault_out     (fault_out),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .dmem_rvalid   (dmem_rvalid)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        dmem_ready   = 1'b0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = 32'hDEADBEEF;
        @(negedge clk);
    endtask

    // Drives one store; returns what the bus saw at the handshake and the stall count.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                             input int ready_wait, output int stalls, output logic [31:0] a,
                             output logic [3:0] s, output logic [31:0] d, output logic we,
                             output logic req);
        stalls = 0; a = '0; s = '0; d = '0; we = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        mem_write_in = 1'b1; mem_read_in = 1'b0; funct3_in = f3;
        alu_result_in = addr; write_data_in = wd; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        if (stall_out) stalls++;
        for (int k = 1; k <= ready_wait + 1; k++) begin
            @(posedge clk); #1;
            dmem_ready = (k == ready_wait + 1);
            @(negedge clk);
            if (stall_out) stalls++;
            if (k == ready_wait + 1) begin
                a = dmem_addr; s = dmem_wstrb; d = dmem_wdata; we = dmem_we; req = dmem_req;
            end
        end
        $display("store f3=%b addr=%h wd=%h -> addr=%h wstrb=%b wdata=%h stalls=%0d", f3, addr, wd, a, s, d, stalls);
    endtask

    // Drives one load; stable reports whether the request fields held steady until the handshake.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                            input int ready_wait, input int rvalid_wait, output int stalls,
                            output logic [31:0] a, output logic [31:0] rd, output logic stable);
        int hs, rv;
        hs = ready_wait + 1;
        rv = hs + rvalid_wait;
        stalls = 0; a = '0; rd = '0; stable = 1'b1;
        @(posedge clk); #1;
        mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = f3;
        alu_result_in = addr; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        if (stall_out) stalls++;
        for (int k = 1; k <= rv; k++) begin
            @(posedge clk); #1;
            dmem_ready  = (k == hs);
            dmem_rvalid = (k == rv);
            dmem_rdata  = (k == rv) ? rdata : 32'hDEADBEEF;
            @(negedge clk);
            if (stall_out) stalls++;
            if (k == 1) a = dmem_addr;
            if (k <= hs && (dmem_req !== 1'b1 || dmem_addr !== a || dmem_we !== 1'b0 || dmem_wstrb !== 4'b0000))
                stable = 1'b0;
            if (k == rv) rd = read_data_out;
        end
        $display("load f3=%b addr=%h rdata=%h -> addr=%h data=%h stalls=%0d", f3, addr, rdata, a, rd, stalls);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'b000;
        alu_result_in = 32'h0; write_data_in = 32'h0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wstrb !== 4'b0000 || dmem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h wstrb=%b wdata=%h expected all zero", dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
        end
        checks++;
        if (read_data_out !== 32'h0 || stall_out !== 1'b0 || fault_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got rd=%h stall=%b fault=%b expected 0/0/0", read_data_out, stall_out, fault_out);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        $display("reset applied and released");
    endtask

    task automatic test_store();
        int st; logic [31:0] a, d; logic [3:0] s; logic we, req;
        run_store(F3_B, 32'h0000_1003, 32'h0000_00AB, 0, st, a, s, d, we, req);
        checks++;
        if (a !== 32'h0000_1000 || s !== 4'b1000 || d !== 32'hABABABAB || we !== 1'b1 || req !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus: got addr=%h wstrb=%b wdata=%h we=%b req=%b expected 00001000/1000/abababab/1/1", a, s, d, we, req);
        end
        checks++;
        if (st !== 1) begin
            errors++;
            $display("FAIL sb_stall: got %0d stall cycles expected 1", st);
        end
        idle_cycle();
        checks++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL sb_done: got req=%b stall=%b expected 0/0", dmem_req, stall_out);
        end
        run_store(F3_H, 32'h0000_1002, 32'h5555_1234, 1, st, a, s, d, we, req);
        checks++;
        if (a !== 32'h0000_1000 || s !== 4'b1100 || d !== 32'h12341234 || st !== 2) begin
            errors++;
            $display("FAIL sh_wait: got addr=%h wstrb=%b wdata=%h stalls=%0d expected 00001000/1100/12341234/2", a, s, d, st);
        end
        idle_cycle();
    endtask

    task automatic test_load_sign();
        int st; logic [31:0] a, rd; logic stable;
        run_load(F3_B, 32'h0000_2001, 32'h0000_80FF, 0, 1, st, a, rd, stable);
        checks++;
        if (rd !== 32'hFFFFFF80 || a !== 32'h0000_2000) begin
            errors++;
            $display("FAIL lb_data: got data=%h addr=%h expected ffffff80/00002000", rd, a);
        end
        checks++;
        if (st !== 2 || stable !== 1'b1) begin
            errors++;
            $display("FAIL lb_timing: got stalls=%0d stable=%b expected 2/1", st, stable);
        end
        idle_cycle();
        checks++;
        if (read_data_out !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_hold: got %h expected ffffff80", read_data_out);
        end
        run_load(F3_BU, 32'h0000_2001, 32'h0000_80FF, 0, 1, st, a, rd, stable);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_data: got %h expected 00000080", rd);
        end
        idle_cycle();
    endtask

    task automatic test_load_wait();
        int st; logic [31:0] a, rd; logic stable;
        run_load(F3_W, 32'h0000_3000, 32'h1357_9BDF, 3, 2, st, a, rd, stable);
        checks++;
        if (rd !== 32'h13579BDF || a !== 32'h0000_3000) begin
            errors++;
            $display("FAIL lw_data: got data=%h addr=%h expected 13579bdf/00003000", rd, a);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL lw_stable: got %b expected 1", stable);
        end
        checks++;
        if (st !== 6) begin
            errors++;
            $display("FAIL lw_stall: got %0d stall cycles expected 6", st);
        end
        idle_cycle();
    endtask

    task automatic test_fault();
        @(posedge clk); #1;
        mem_read_in = 1'b1; funct3_in = F3_H; alu_result_in = 32'h0000_4001;
        @(negedge clk);
        checks++;
        if (fault_out !== 1'b1 || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL lh_misaligned: got fault=%b stall=%b req=%b expected 1/0/0", fault_out, stall_out, dmem_req);
        end
        @(posedge clk); #1;
        funct3_in = 3'b011; alu_result_in = 32'h0000_4000;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL fault_noreq: got req=%b expected 0", dmem_req);
        end
        checks++;
        if (fault_out !== 1'b1 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL f3_illegal: got fault=%b stall=%b expected 1/0", fault_out, stall_out);
        end
        idle_cycle();
        checks++;
        if (fault_out !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got %b expected 0", fault_out);
        end
        $display("fault checks done");
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] a, d, rd; logic [3:0] s; logic we, req, stable;
        run_store(F3_W, 32'h0000_5000, 32'hCAFEF00D, 0, st, a, s, d, we, req);
        checks++;
        if (a !== 32'h0000_5000 || s !== 4'b1111 || d !== 32'hCAFEF00D || st !== 1) begin
            errors++;
            $display("FAIL b2b_sw: got addr=%h wstrb=%b wdata=%h stalls=%0d expected 00005000/1111/cafef00d/1", a, s, d, st);
        end
        run_load(F3_HU, 32'h0000_5002, 32'hBEEF_0000, 0, 1, st, a, rd, stable);
        checks++;
        if (rd !== 32'h0000BEEF || a !== 32'h0000_5000 || st !== 2 || stable !== 1'b1) begin
            errors++;
            $display("FAIL b2b_lhu: got data=%h addr=%h stalls=%0d stable=%b expected 0000beef/00005000/2/1", rd, a, st, stable);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mem_read_in = 1'b1; funct3_in = F3_W; alu_result_in = 32'h0000_6000;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL resp_stall: got %b expected 1", stall_out);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; mem_read_in = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || read_data_out !== 32'h0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got req=%b rd=%h stall=%b expected 0/00000000/0", dmem_req, read_data_out, stall_out);
        end
        idle_cycle();
        checks++;
        if (read_data_out !== 32'h0) begin
            errors++;
            $display("FAIL late_rvalid: got %h expected 00000000", read_data_out);
        end
        $display("reset during RESP done");
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_sign();
        test_load_wait();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
